// File: rtl/id_ex_dump_unit.sv
// ============================================================================
// Module  : id_ex_dump_unit
// Brief   : Snapshots the seven ID/EX fields on request and streams them out
//           byte-wise (field 0..6, LSB first) over a valid/ready byte port.
//           Define ID_EX_DUMP_CSUM_EN to append an XOR checksum byte.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_dump_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_pc_next,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic                  i_start,
    input  logic                  i_tx_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int c_FIELD_BYTES = DATA_WIDTH / 8;
    localparam int c_TOTAL_BYTES = 7 * c_FIELD_BYTES;
    localparam int c_SHADOW_W    = 7 * DATA_WIDTH;
    localparam int c_CNT_W       = $clog2(c_TOTAL_BYTES);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(c_TOTAL_BYTES - 1);

    generate
        if ((DATA_WIDTH % 8 != 0) || (DATA_WIDTH < 8) || (DATA_WIDTH > 64)) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of 8 in the range 8..64");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
`ifdef ID_EX_DUMP_CSUM_EN
        S_CSUM = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_SHADOW_W-1:0] r_shadow;
    logic [c_CNT_W-1:0]    r_count;
    logic [7:0]            w_tx_data;
    logic                  w_tx_valid;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_snap;
    logic                  w_data_xfer;
`ifdef ID_EX_DUMP_CSUM_EN
    logic [7:0]            r_csum;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_tx_data    = 8'h00;
        w_tx_valid   = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_snap       = 1'b0;
        w_data_xfer  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_snap       = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                w_tx_data   = r_shadow[7:0];
                w_tx_valid  = 1'b1;
                w_busy      = 1'b1;
                w_data_xfer = i_tx_ready;
                if (i_tx_ready && (r_count == c_LAST_IDX)) begin
`ifdef ID_EX_DUMP_CSUM_EN
                    w_state_next = S_CSUM;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef ID_EX_DUMP_CSUM_EN
            S_CSUM: begin
                w_tx_data  = r_csum;
                w_tx_valid = 1'b1;
                w_busy     = 1'b1;
                if (i_tx_ready) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shadow buffer: a shift register so the outgoing byte is always bits [7:0]
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_shadow <= '0;
            r_count  <= '0;
        end else if (w_snap) begin
            r_shadow <= {i_instr, i_imm, i_rs2_data, i_rs1_data, i_pc_next, i_pc, i_ctrl};
            r_count  <= '0;
        end else if (w_data_xfer) begin
            r_shadow <= {8'h00, r_shadow[c_SHADOW_W-1:8]};
            r_count  <= r_count + 1'b1;
        end
    end

`ifdef ID_EX_DUMP_CSUM_EN
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_csum <= 8'h00;
        end else if (w_snap) begin
            r_csum <= 8'h00;
        end else if (w_data_xfer) begin
            r_csum <= r_csum ^ r_shadow[7:0];
        end
    end
`endif

    assign o_tx_data  = w_tx_data;
    assign o_tx_valid = w_tx_valid;
    assign o_busy     = w_busy;
    assign o_done     = w_done;

endmodule

`default_nettype wire

// File: doc/id_ex_dump_unit.md
ID_EX_DUMP_UNIT -- requirements
Module: id_ex_dump_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each ID/EX field; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_ctrl, i_pc, i_pc_next, i_rs1_data, i_rs2_data, i_imm, i_instr  input  DATA_WIDTH each  live ID/EX register outputs (field index 0..6 in that order).
REQ-005 SHALL have port i_start  input  1  dump request from debug unit.
REQ-006 SHALL have port i_tx_ready  input  1  downstream (UART TX) accepts a byte.
REQ-007 SHALL have port o_tx_data  output  8  byte being offered.
REQ-008 SHALL have port o_tx_valid  output  1  o_tx_data is valid.
REQ-009 SHALL have port o_busy  output  1  dump in progress.
REQ-010 SHALL have port o_done  output  1  single-cycle pulse, dump complete.

Function
REQ-011 SHALL implement FSM states IDLE, SEND, CSUM, DONE; o_busy=1 in SEND and CSUM only.
REQ-012 In IDLE, i_start=1 at a clock edge SHALL snapshot all 7 fields into an internal shadow buffer, clear word/byte counters, and enter SEND.
REQ-013 Inputs SHALL be ignored after the snapshot; pipeline changes during a dump do not affect output bytes.
REQ-014 i_start SHALL be ignored in SEND, CSUM and DONE (no restart, no queuing).
REQ-015 First byte SHALL be presented with o_tx_valid=1 in the cycle immediately following the start edge (latency 1).
REQ-016 Byte order SHALL be field 0 to field 6; within a field, least-significant byte first; total 7*DATA_WIDTH/8 data bytes (28 at default).
REQ-017 A transfer SHALL occur at a clock edge where o_tx_valid=1 and i_tx_ready=1; only then do counters advance.
REQ-018 While o_tx_valid=1 and no transfer occurs, o_tx_data SHALL remain stable and o_tx_valid SHALL not deassert.
REQ-019 With i_tx_ready held high, one byte SHALL transfer per cycle with no bubbles, including across field boundaries and into CSUM.
REQ-020 Transfer of the last data byte SHALL move to CSUM when checksum is compiled in, otherwise directly to DONE.
REQ-021 In CSUM, o_tx_data SHALL be the checksum byte under the same handshake; its transfer moves to DONE.
REQ-022 DONE SHALL last exactly one cycle with o_done=1, o_tx_valid=0, o_busy=0, then return to IDLE.
REQ-023 In IDLE and DONE, o_tx_valid SHALL be 0 and o_tx_data SHALL be 8'h00.
REQ-024 i_tx_ready asserted while o_tx_valid=0 SHALL have no effect.

Reset
REQ-025 i_rst=1 at a clock edge SHALL force IDLE, clear counters, shadow buffer and checksum, regardless of state (including mid-dump); i_rst has priority over i_start.
REQ-026 Post-reset outputs SHALL be o_tx_data=8'h00, o_tx_valid=0, o_busy=0, o_done=0; an aborted dump does not produce o_done.

Configuration
REQ-027 Macro ID_EX_DUMP_CSUM_EN, when defined, SHALL include a running 8-bit XOR checksum of all data bytes transferred (cleared on start) and the CSUM state, giving 7*DATA_WIDTH/8+1 bytes per dump.
REQ-028 Without ID_EX_DUMP_CSUM_EN, the checksum register and CSUM state SHALL be absent and SEND SHALL go straight to DONE.

Verification
REQ-029 Default params, no macro, fields = 0x00000011, 0x00000100, 0x00000104, 0xDEADBEEF, 0x12345678, 0xFFFFF800, 0x00A00093, i_tx_ready=1 -> 28 back-to-back bytes 11 00 00 00 00 01 00 00 04 01 00 00 EF BE AD DE 78 56 34 12 00 F8 FF FF 93 00 A0 00, first byte 1 cycle after start, o_done pulses 1 cycle after last transfer.
REQ-030 Same data, i_tx_ready toggling 1 cycle high/2 low, fields changed to 0 after start -> identical 28-byte sequence, o_tx_data stable while stalled.
REQ-031 ID_EX_DUMP_CSUM_EN defined, same data -> 29 bytes, last byte equals XOR of the 28 data bytes.
REQ-032 i_start pulsed again at byte 10 -> ignored; exactly 28 bytes, one o_done.
REQ-033 i_rst asserted at byte 15 with i_start=1 -> next cycle IDLE, all outputs 0, no o_done; subsequent start yields full correct dump.
REQ-034 DATA_WIDTH=8, fields 0x01..0x07 -> bytes 01 02 03 04 05 06 07, then o_done.
